// File: rtl/exe_divider.sv
// Iterative restoring divider (DIV/DIVU) for the execute stage: one quotient bit per
// cycle, operands in and quotient/remainder out over valid/ready handshakes.
module exe_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_x,
  input  logic [WIDTH-1:0] div_y,
  input  logic             cancel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on any rising edge where valid & ready are both high;
  // the producer holds its data stable until then, and ready never depends on valid.

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH:0]   r_shift;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    q_d     = q_q;
    r_d     = r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    r_shift = {r_q, x_q[WIDTH-1]};

    case (state_q)
      IDLE: begin
        if (div_valid && !cancel) begin
          x_d    = (div_signed && div_x[WIDTH-1]) ? -div_x : div_x;
          y_d    = (div_signed && div_y[WIDTH-1]) ? -div_y : div_y;
          // A zero divisor must leave the all-ones quotient uncorrected.
          qneg_d = div_signed && (div_x[WIDTH-1] ^ div_y[WIDTH-1]) && (|div_y);
          rneg_d = div_signed && div_x[WIDTH-1];
          q_d    = '0;
          r_d    = '0;
          cnt_d  = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == CW'(WIDTH)) begin
          quot_d  = qneg_q ? -q_q : q_q;
          rem_d   = rneg_q ? -r_q : r_q;
          state_d = DONE;
        end else begin
          x_d = {x_q[WIDTH-2:0], 1'b0};
          if (r_shift >= {1'b0, y_q}) begin
            r_d = WIDTH'(r_shift - {1'b0, y_q});
            q_d = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            r_d = r_shift[WIDTH-1:0];
            q_d = {q_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cancel) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      q_q     <= q_d;
      r_q     <= r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign div_ready = (state_q == IDLE) && resetn;
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_exe_divider.sv
// Bench for exe_divider: 32-bit and 8-bit instances, scoreboarded results, latency,
// backpressure, cancel and reset scenarios.
module tb_exe_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        resetn, div_valid, div_signed, cancel, res_ready;
  logic [31:0] div_x, div_y;
  logic        div_ready, res_valid, busy;
  logic [31:0] quotient, remainder;
  logic [1:0]  dbg_state;

  logic        w8_resetn, w8_div_valid, w8_div_signed, w8_cancel, w8_res_ready;
  logic [7:0]  w8_div_x, w8_div_y;
  logic        w8_div_ready, w8_res_valid, w8_busy;
  logic [7:0]  w8_quotient, w8_remainder;
  logic [1:0]  w8_dbg_state;

  exe_divider #(.WIDTH(32)) u_div32 (
    .clk(clk), .resetn(resetn), .div_valid(div_valid), .div_ready(div_ready),
    .div_signed(div_signed), .div_x(div_x), .div_y(div_y), .cancel(cancel),
    .res_valid(res_valid), .res_ready(res_ready), .quotient(quotient),
    .remainder(remainder), .busy(busy), .dbg_state(dbg_state)
  );

  exe_divider #(.WIDTH(8)) u_div8 (
    .clk(clk), .resetn(w8_resetn), .div_valid(w8_div_valid), .div_ready(w8_div_ready),
    .div_signed(w8_div_signed), .div_x(w8_div_x), .div_y(w8_div_y), .cancel(w8_cancel),
    .res_valid(w8_res_valid), .res_ready(w8_res_ready), .quotient(w8_quotient),
    .remainder(w8_remainder), .busy(w8_busy), .dbg_state(w8_dbg_state)
  );

  logic [63:0] exp_q[$];
  logic [15:0] exp8_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int last_acc = 0;

  function automatic logic [63:0] model32(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] q, r;
    if (y == 32'd0) begin
      q = '1; r = x;
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (s) begin
      q = 32'($signed(x) / $signed(y));
      r = 32'($signed(x) % $signed(y));
    end else begin
      q = x / y; r = x % y;
    end
    return {q, r};
  endfunction

  // Drive one operation at a negedge; returns at the negedge after the accept edge.
  task automatic issue32(input logic s, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] e, input bit push);
    div_valid = 1'b1; div_signed = s; div_x = x; div_y = y;
    n_checks++;
    if (div_ready !== 1'b1) begin
      n_errors++; $display("FAIL issue_ready got %b want 1", div_ready);
    end
    if (push) exp_q.push_back(e);
    @(negedge clk);
    last_acc = cyc;
    div_valid = 1'b0; div_signed = 1'($urandom_range(0, 1)); div_x = $urandom; div_y = $urandom;
  endtask

  task automatic collect32(input string name, input int exp_lat);
    int k;
    logic [63:0] e;
    k = 0;
    while (res_valid !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    n_checks++;
    if (k != exp_lat) begin
      n_errors++; $display("FAIL %s latency got %0d want %0d", name, k, exp_lat);
    end
    if (res_valid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (quotient !== e[63:32]) begin
        n_errors++; $display("FAIL %s quotient got %h want %h", name, quotient, e[63:32]);
      end
      n_checks++;
      if (remainder !== e[31:0]) begin
        n_errors++; $display("FAIL %s remainder got %h want %h", name, remainder, e[31:0]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0 || div_ready !== 1'b1) begin
      n_errors++; $display("FAIL %s post_handshake res_valid=%b div_ready=%b want 0/1", name, res_valid, div_ready);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; w8_resetn = 1'b0;
    div_valid = 0; div_signed = 0; div_x = 0; div_y = 0; cancel = 0; res_ready = 0;
    w8_div_valid = 0; w8_div_signed = 0; w8_div_x = 0; w8_div_y = 0; w8_cancel = 0; w8_res_ready = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (div_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready_low got %b want 0", div_ready); end
    resetn = 1'b1; w8_resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (div_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_state got rdy=%b vld=%b busy=%b q=%h r=%h want 1 0 0 0 0",
               div_ready, res_valid, busy, quotient, remainder);
    end
  endtask

  task automatic test_unsigned();
    res_ready = 1'b1;
    issue32(1'b0, 32'd100, 32'd7, {32'd14, 32'd2}, 1);
    collect32("udiv_100_7", 33);
  endtask

  task automatic test_signed();
    issue32(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, 1);
    collect32("sdiv_m7_2", 33);
    issue32(1'b1, 32'd7, 32'hFFFF_FFFE, {32'hFFFF_FFFD, 32'd1}, 1);
    collect32("sdiv_7_m2", 33);
    issue32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 1);
    collect32("sdiv_overflow", 33);
  endtask

  task automatic test_div_zero();
    issue32(1'b0, 32'd5, 32'd0, {32'hFFFF_FFFF, 32'd5}, 1);
    collect32("udiv_by_zero", 33);
    issue32(1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFF, 32'hFFFF_FFFB}, 1);
    collect32("sdiv_by_zero", 33);
  endtask

  task automatic test_backpressure();
    int k;
    res_ready = 1'b0;
    issue32(1'b0, 32'd1000, 32'd9, {32'd111, 32'd1}, 1);
    k = 0;
    while (res_valid !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    n_checks++;
    if (k != 33) begin n_errors++; $display("FAIL bp_latency got %0d want 33", k); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (res_valid !== 1'b1 || div_ready !== 1'b0 || quotient !== 32'd111 || remainder !== 32'd1) begin
        n_errors++;
        $display("FAIL bp_hold cycle %0d vld=%b rdy=%b q=%0d r=%0d want 1 0 111 1",
                 i, res_valid, div_ready, quotient, remainder);
      end
      div_valid = (i == 4); div_x = 32'd7; div_y = 32'd1; div_signed = 1'b0;
      @(negedge clk);
    end
    div_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    void'(exp_q.pop_front());
    n_checks++;
    if (res_valid !== 1'b0 || div_ready !== 1'b1 || quotient !== 32'd111 || remainder !== 32'd1) begin
      n_errors++;
      $display("FAIL bp_release vld=%b rdy=%b q=%0d r=%0d want 0 1 111 1", res_valid, div_ready, quotient, remainder);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL bp_no_accept busy got %b want 0", busy); end
  endtask

  task automatic test_cancel();
    bit seen;
    int k;
    issue32(1'b0, 32'd50, 32'd5, '0, 0);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || div_ready !== 1'b1 || busy !== 1'b0 || quotient !== 32'd111 || remainder !== 32'd1) begin
      n_errors++;
      $display("FAIL cancel_calc vld=%b rdy=%b busy=%b q=%0d r=%0d want 0 1 0 111 1",
               res_valid, div_ready, busy, quotient, remainder);
    end
    seen = 0;
    repeat (40) begin @(negedge clk); if (res_valid === 1'b1) seen = 1; end
    n_checks++;
    if (seen) begin n_errors++; $display("FAIL cancel_no_result res_valid got 1 want 0"); end
    issue32(1'b0, 32'd9, 32'd3, {32'd3, 32'd0}, 1);
    collect32("after_cancel_9_3", 33);

    div_valid = 1'b1; cancel = 1'b1; div_x = 32'd20; div_y = 32'd4; div_signed = 1'b0;
    @(negedge clk);
    div_valid = 1'b0; cancel = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || div_ready !== 1'b1) begin
      n_errors++; $display("FAIL cancel_idle busy=%b rdy=%b want 0 1", busy, div_ready);
    end

    res_ready = 1'b0;
    issue32(1'b0, 32'd77, 32'd7, '0, 0);
    k = 0;
    while (res_valid !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    n_checks++;
    if (k != 33 || quotient !== 32'd11) begin
      n_errors++; $display("FAIL cancel_done_setup lat=%0d q=%0d want 33 11", k, quotient);
    end
    cancel = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || div_ready !== 1'b1 || quotient !== 32'd11 || remainder !== 32'd0) begin
      n_errors++;
      $display("FAIL cancel_done vld=%b rdy=%b q=%0d r=%0d want 0 1 11 0", res_valid, div_ready, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    logic        s;
    logic [31:0] x, y;
    int          prev;
    res_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      s = 1'($urandom_range(0, 1));
      x = (i == 5) ? 32'h8000_0000 : $urandom;
      y = (i == 3) ? 32'd0 : (i == 5) ? 32'hFFFF_FFFF :
          ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      issue32(s, x, y, model32(s, x, y), 1);
      if (i > 0) begin
        n_checks++;
        if (last_acc - prev != 35) begin
          n_errors++; $display("FAIL b2b_interval got %0d want 35", last_acc - prev);
        end
      end
      prev = last_acc;
      collect32("b2b_random", 33);
    end
  endtask

  task automatic test_width8();
    int k;
    logic [7:0]  x, y;
    logic [15:0] e;
    w8_res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x = (i == 0) ? 8'd200 : 8'($urandom);
      y = (i == 0) ? 8'd3 : (i == 2) ? 8'd0 : 8'($urandom);
      exp8_q.push_back((y == 8'd0) ? {8'hFF, x} : {8'(x / y), 8'(x % y)});
      w8_div_valid = 1'b1; w8_div_signed = 1'b0; w8_div_x = x; w8_div_y = y;
      @(negedge clk);
      w8_div_valid = 1'b0; w8_div_x = 8'($urandom); w8_div_y = 8'($urandom);
      k = 0;
      while (w8_res_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      n_checks++;
      if (k != 9) begin n_errors++; $display("FAIL w8_latency got %0d want 9", k); end
      e = exp8_q.pop_front();
      n_checks++;
      if (w8_quotient !== e[15:8] || w8_remainder !== e[7:0]) begin
        n_errors++;
        $display("FAIL w8_result %0d/%0d got q=%0d r=%0d want q=%0d r=%0d", x, y, w8_quotient, w8_remainder, e[15:8], e[7:0]);
      end
      @(negedge clk);
    end

    w8_div_valid = 1'b1; w8_div_x = 8'd250; w8_div_y = 8'd7;
    @(negedge clk);
    w8_div_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (w8_busy !== 1'b1) begin n_errors++; $display("FAIL w8_mid_calc busy got %b want 1", w8_busy); end
    w8_resetn = 1'b0;
    @(negedge clk);
    n_checks++;
    if (w8_res_valid !== 1'b0 || w8_quotient !== 8'd0 || w8_remainder !== 8'd0 || w8_div_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL w8_in_reset vld=%b q=%0d r=%0d rdy=%b want 0 0 0 0", w8_res_valid, w8_quotient, w8_remainder, w8_div_ready);
    end
    w8_resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (w8_div_ready !== 1'b1 || w8_busy !== 1'b0 || w8_res_valid !== 1'b0) begin
      n_errors++; $display("FAIL w8_after_reset rdy=%b busy=%b vld=%b want 1 0 0", w8_div_ready, w8_busy, w8_res_valid);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_backpressure();
    test_cancel();
    test_back_to_back();
    test_width8();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
